// File: rtl/nested_req_ack_responder.sv
// Responder end of the nested-include req/ack channel: queues requests, serves them after a fixed latency.
// Optional valid/payload stability checker enabled by NESTED_REQ_ACK_RESPONDER_PROTOCHK_EN (adds proto_err).
module nested_req_ack_responder #(
  parameter int DSIZE   = 1,
  parameter int DSIZE2  = 2,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_vld,
  input  logic [DSIZE2-1:0]            req_data,
  output logic                         req_rdy,
  output logic                         ack_vld,
  output logic [DSIZE-1:0]             ack_data,
  input  logic                         ack_rdy,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef NESTED_REQ_ACK_RESPONDER_PROTOCHK_EN
  ,
  output logic                         proto_err
`endif
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CNTW-1:0] LAT_LOAD = CNTW'(LATENCY - 1);

  if (DSIZE2 != 2 * DSIZE) begin : g_bad_dsize
    $error("DSIZE2 must equal 2*DSIZE");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [DSIZE-1:0]        ack_data_q, ack_data_d;
  logic [DSIZE2-1:0]       mem_q [DEPTH];
  logic [DSIZE2-1:0]       mem_d [DEPTH];
  logic [DSIZE2-1:0]       head;
  logic                    push, pop;

  // Acceptance looks only at registered occupancy, so a full FIFO refuses even while popping.
  assign req_rdy  = rst_n && (count_q < DEPTH_C);
  assign ack_vld  = (state_q == RESP);
  assign ack_data = ack_data_q;
  assign count    = count_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);
  assign push     = req_vld && req_rdy;
  assign pop      = ack_vld && ack_rdy;
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = req_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ack_data_d = ack_data_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = WAIT;
          cnt_d   = LAT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          ack_data_d = head[DSIZE-1:0] ^ head[DSIZE2-1:DSIZE];
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RESP: begin
        // Occupancy after the pop (including any same-edge push) decides whether to keep serving.
        if (ack_rdy) begin
          if (count_d != '0) begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_data_q <= ack_data_d;
    end
  end

  // Storage needs no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef NESTED_REQ_ACK_RESPONDER_PROTOCHK_EN
  logic              blocked_q, blocked_d;
  logic [DSIZE2-1:0] prev_data_q, prev_data_d;
  logic              proto_err_q, proto_err_d;

  always_comb begin
    blocked_d   = req_vld && !req_rdy;
    prev_data_d = req_data;
    proto_err_d = proto_err_q;
    if (blocked_q && (!req_vld || (req_data != prev_data_q))) begin
      proto_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blocked_q   <= 1'b0;
      prev_data_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      blocked_q   <= blocked_d;
      prev_data_q <= prev_data_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_nested_req_ack_responder.sv
// Scoreboard bench for nested_req_ack_responder: expected acks are queued on acceptance and compared on handshake.
module tb_nested_req_ack_responder;

  localparam int DSIZE   = 1;
  localparam int DSIZE2  = 2;
  localparam int DEPTH   = 4;
  localparam int LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_vld = 1'b0;
  logic [DSIZE2-1:0] req_data = '0;
  logic              req_rdy;
  logic              ack_vld;
  logic [DSIZE-1:0]  ack_data;
  logic              ack_rdy = 1'b0;
  logic              busy;
  logic [2:0]        count;
`ifdef NESTED_REQ_ACK_RESPONDER_PROTOCHK_EN
  logic              proto_err;
`endif

  nested_req_ack_responder #(
    .DSIZE(DSIZE), .DSIZE2(DSIZE2), .DEPTH(DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_vld(req_vld),
    .req_data(req_data),
    .req_rdy(req_rdy),
    .ack_vld(ack_vld),
    .ack_data(ack_data),
    .ack_rdy(ack_rdy),
    .busy(busy),
    .count(count)
`ifdef NESTED_REQ_ACK_RESPONDER_PROTOCHK_EN
    ,
    .proto_err(proto_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DSIZE-1:0] sb [$];
  bit gap_en = 1'b0;
  bit gap_prev = 1'b0;
  int last_hs = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  // Sample on the falling edge: what is seen here is exactly what the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      gap_prev = 1'b0;
    end else begin
      if (ack_vld && ack_rdy) begin
        if (sb.size() == 0) checkOutput("sb_empty", 1, 0);
        else checkOutput("ack_data", 32'(ack_data), 32'(sb.pop_front()));
        if (gap_en) begin
          if (gap_prev) checkOutput("hs_gap", cyc - last_hs, LATENCY + 1);
          gap_prev = 1'b1;
          last_hs  = cyc;
        end
      end
      if (req_vld && req_rdy) sb.push_back(req_data[0] ^ req_data[1]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input logic [DSIZE2-1:0] d);
    logic ok;
    ok = 1'b0;
    req_vld  = 1'b1;
    req_data = d;
    for (int i = 0; i < 200; i++) begin
      ok = req_rdy;
      tick();
      if (ok) break;
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
    req_vld = 1'b0;
  endtask

  task automatic waitAck(input int bound);
    int n;
    n = 0;
    while (!ack_vld && n < bound) begin
      tick();
      n++;
    end
    if (!ack_vld) checkOutput("ack_timeout", 0, 1);
  endtask

  task automatic waitIdle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    if (busy) checkOutput("idle_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit seen;

    tick();
    checkOutput("rst_req_rdy", 32'(req_rdy), 0);
    checkOutput("rst_ack_vld", 32'(ack_vld), 0);
    checkOutput("rst_ack_data", 32'(ack_data), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_count", 32'(count), 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_req_rdy", 32'(req_rdy), 1);

    // Single request: ack_vld first high after edge E+LATENCY+1
    ack_rdy = 1'b1;
    applyStimulus(2'b10);
    checkOutput("lat_e0", 32'(ack_vld), 0);
    checkOutput("single_count", 32'(count), 1);
    tick();
    checkOutput("lat_e1", 32'(ack_vld), 0);
    checkOutput("single_busy", 32'(busy), 1);
    tick();
    checkOutput("lat_e2", 32'(ack_vld), 0);
    tick();
    checkOutput("lat_e3", 32'(ack_vld), 1);
    checkOutput("single_data", 32'(ack_data), 1);
    tick();
    checkOutput("single_vld_drop", 32'(ack_vld), 0);
    checkOutput("single_count_end", 32'(count), 0);
    checkOutput("single_busy_end", 32'(busy), 0);

    // Fill to full under backpressure, then drain in order
    ack_rdy = 1'b0;
    applyStimulus(2'b00);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    checkOutput("full_count", 32'(count), 4);
    checkOutput("full_req_rdy", 32'(req_rdy), 0);
    req_vld  = 1'b1;
    req_data = 2'b01;
    repeat (3) tick();
    checkOutput("full_no_accept", 32'(count), 4);
    req_vld = 1'b0;
    checkOutput("full_head_vld", 32'(ack_vld), 1);
    checkOutput("full_head_data", 32'(ack_data), 0);
    gap_en  = 1'b1;
    ack_rdy = 1'b1;
    waitIdle(100);
    gap_en  = 1'b0;
    checkOutput("full_sb_drained", sb.size(), 0);
    checkOutput("full_count_end", 32'(count), 0);

    // Simultaneous push and pop at count 2 across pointer wrap
    ack_rdy = 1'b0;
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    for (int i = 0; i < 10; i++) begin
      waitAck(50);
      ack_rdy  = 1'b1;
      req_vld  = 1'b1;
      req_data = 2'($urandom_range(0, 3));
      checkOutput("pp_req_rdy", 32'(req_rdy), 1);
      tick();
      ack_rdy = 1'b0;
      req_vld = 1'b0;
      checkOutput("pp_count", 32'(count), 2);
    end
    ack_rdy = 1'b1;
    waitIdle(100);
    checkOutput("pp_sb_drained", sb.size(), 0);

    // Ack backpressure holds output steady
    ack_rdy = 1'b0;
    applyStimulus(2'b10);
    waitAck(50);
    for (int i = 0; i < 7; i++) begin
      checkOutput("bp_vld", 32'(ack_vld), 1);
      checkOutput("bp_data", 32'(ack_data), 1);
      checkOutput("bp_count", 32'(count), 1);
      tick();
    end
    ack_rdy = 1'b1;
    tick();
    ack_rdy = 1'b0;
    checkOutput("bp_vld_after", 32'(ack_vld), 0);
    checkOutput("bp_count_after", 32'(count), 0);

    // Reset while requests are queued and the FSM is waiting
    applyStimulus(2'b11);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    checkOutput("mid_count", 32'(count), 3);
    checkOutput("mid_ack_vld", 32'(ack_vld), 0);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_rst_req_rdy", 32'(req_rdy), 0);
    checkOutput("mid_rst_ack_vld", 32'(ack_vld), 0);
    checkOutput("mid_rst_ack_data", 32'(ack_data), 0);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    checkOutput("mid_rst_count", 32'(count), 0);
    rst_n   = 1'b1;
    ack_rdy = 1'b1;
    seen    = 1'b0;
    repeat (20) begin
      tick();
      if (ack_vld) seen = 1'b1;
    end
    checkOutput("mid_no_ack", 32'(seen), 0);
    checkOutput("mid_req_rdy", 32'(req_rdy), 1);

`ifdef NESTED_REQ_ACK_RESPONDER_PROTOCHK_EN
    // Payload change while blocked sets the sticky error
    checkOutput("pe_clear", 32'(proto_err), 0);
    ack_rdy = 1'b0;
    applyStimulus(2'b00);
    applyStimulus(2'b01);
    applyStimulus(2'b10);
    applyStimulus(2'b11);
    req_vld  = 1'b1;
    req_data = 2'b01;
    tick();
    checkOutput("pe_blocked_ok", 32'(proto_err), 0);
    req_data = 2'b10;
    tick();
    checkOutput("pe_set", 32'(proto_err), 1);
    req_vld = 1'b0;
    repeat (50) tick();
    checkOutput("pe_sticky", 32'(proto_err), 1);
    applyReset();
    tick();
    checkOutput("pe_reset", 32'(proto_err), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nested_req_ack_responder.md
Name: nested_req_ack_responder

Overview:
- Responder (target) end of the mixedNestedInclude request/acknowledge channel, paired with the existing initiator.
- Accepts DSIZE2-wide requests into a small FIFO.
- Services each request after a fixed latency and returns a DSIZE-wide acknowledge payload over a valid/ready handshake.
- Sits between the nested-include initiator and downstream logic; also reports occupancy and busy status.

Parameters:
DSIZE, 1, acknowledge payload width (matches package constant DSIZE)
DSIZE2, 2, request payload width (matches package constant DSIZE2); must equal 2*DSIZE, otherwise elaboration error
DEPTH, 4, request FIFO entries; power of two, >=2
LATENCY, 2, service cycles per request; >=1, otherwise elaboration error

Ports:
clk  in  1  single clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
req_vld  in  1  request valid from initiator
req_data  in  DSIZE2  request payload
req_rdy  out  1  responder can accept a request
ack_vld  out  1  acknowledge valid
ack_data  out  DSIZE  acknowledge payload
ack_rdy  in  1  initiator accepts acknowledge
busy  out  1  FIFO non-empty or FSM not IDLE
count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst_n low at a clk edge): req_rdy=0 during reset, ack_vld=0, ack_data=0, busy=0, count=0, FSM=IDLE, pointers=0, latency counter=0. Reset mid-transaction discards all queued entries and any pending ack; no ack is issued after reset for pre-reset requests.
- Accept: a request is accepted on any edge with req_vld && req_rdy. req_rdy = (count < DEPTH), from registered count only, so a full FIFO never accepts, even if a pop occurs in the same cycle.
- FIFO: circular buffer, write and read pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0. count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Strict in-order service.
- Pop: occurs on the edge where ack_vld && ack_rdy.
- FSM states:
  - IDLE: if count!=0, go to WAIT and load cnt=LATENCY-1.
  - WAIT: decrement cnt each cycle. When cnt==0, go to RESP and register ack_data from the head entry.
  - RESP: hold ack_vld=1 and ack_data stable until ack_rdy. On handshake, pop the head. If count after pop is !=0, go to WAIT with cnt=LATENCY-1; otherwise go to IDLE.
- Latency:
  - Empty block, request accepted at edge E: ack_vld first high after edge E+LATENCY+1.
  - Back-to-back queued requests: next ack_vld rises LATENCY edges after the previous ack handshake edge.
- ack_data = req_data[DSIZE-1:0] XOR req_data[DSIZE2-1:DSIZE] of the serviced entry.
- ack_rdy low in RESP: stall indefinitely; requests continue to be accepted until full.
- busy is combinational from registered state: (count!=0) || (FSM!=IDLE).

Optional Feature:
- Macro: NESTED_REQ_ACK_RESPONDER_PROTOCHK_EN.
- Defined: adds output proto_err (1 bit, reset 0), a sticky error flag.
  - Set on the edge after any cycle where req_vld was 1 and req_rdy was 0, and in the next cycle either req_vld dropped or req_data changed (valid/payload stability violation).
  - Cleared only by reset.
  - Has no effect on datapath or handshakes.
- Not defined: port and checker logic absent; behaviour otherwise identical.

Test Plan:
- Single request: reset, req_data=2'b10 accepted at edge 5, ack_rdy=1 -> ack_vld high after edge 8 (LATENCY=2) for one cycle, ack_data=1'b1, count returns 0, busy 0 afterwards.
- Fill/full: hold ack_rdy=0 and push 2'b00, 2'b01, 2'b10, 2'b11 -> req_rdy=0 with count=4. A fifth req_vld is not accepted. Release ack_rdy -> acks 0,1,1,0 in order, each LATENCY edges after the prior handshake.
- Simultaneous push/pop at count=2: push 2'b11 on the same edge as an ack handshake -> count stays 2, write pointer wraps 3->0 correctly over 10 such iterations with no data loss.
- Ack backpressure: ack_rdy=0 for 7 cycles in RESP -> ack_vld and ack_data held constant and count unchanged. ack_rdy=1 -> single pop.
- Reset mid-operation: 3 entries queued and FSM in WAIT, assert rst_n=0 for 1 cycle -> all outputs at reset values, and no ack appears in the next 20 cycles with req_vld=0.
- With NESTED_REQ_ACK_RESPONDER_PROTOCHK_EN and FIFO full: req_data changes 2'b01->2'b10 while req_vld=1 and req_rdy=0 -> proto_err=1 the next edge, still 1 after 50 cycles, cleared by reset.
